// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: D->E issue register for the multiply/divide unit.
// Registers MDU-class ops and operands into E, hands the MDU its start pulse,
// and tracks MDU occupancy with a latency counter so that a dependent MDU op
// in D is held until the previous mult/div has finished.
module mdu_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        ext_stall,
  input  logic [5:0]  d_type,
  input  logic [31:0] d_rs,
  input  logic [31:0] d_rt,
  output logic [5:0]  e_type,
  output logic [31:0] e_in1,
  output logic [31:0] e_in2,
  output logic        e_start,
  output logic        stall,
  output logic        busy
);

  localparam logic [5:0] OP_MULT  = 6'b010101;
  localparam logic [5:0] OP_MULTU = 6'b010110;
  localparam logic [5:0] OP_DIV   = 6'b010111;
  localparam logic [5:0] OP_DIVU  = 6'b011000;
  localparam logic [5:0] OP_MFHI  = 6'b011001;
  localparam logic [5:0] OP_MFLO  = 6'b011010;
  localparam logic [5:0] OP_MTHI  = 6'b011011;
  localparam logic [5:0] OP_MTLO  = 6'b011100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic d_md;       // D holds any MDU-class op (uses HI/LO or the unit)
  logic d_launch;   // D holds an op that starts the MDU
  logic e_is_mul;   // E holds MULT/MULTU
  logic e_is_div;   // E holds DIV/DIVU

  // Op-class decode of the D and E op codes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    d_md     = 1'b0;
    d_launch = 1'b0;
    case (d_type)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        d_md     = 1'b1;
        d_launch = 1'b1;
      end
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: d_md = 1'b1;
      default: ;
    endcase
    e_is_mul = (e_type == OP_MULT) || (e_type == OP_MULTU);
    e_is_div = (e_type == OP_DIV)  || (e_type == OP_DIVU);
  end

  assign busy  = (cnt != '0);
  // An MDU op in D must wait both for an op about to start (still in E) and for
  // one already running; anything else in D is not this block's concern.
  assign stall = d_md & (e_start | busy);

  // Occupancy FSM: a start that survives to the edge (no Req) loads the latency
  // of its class; the counter then runs down to zero regardless of later Req,
  // because an op that has left E is already committed inside the MDU.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (e_start && !Req && e_is_mul) begin
      // Reload also covers a start while busy, which stall should prevent.
      state <= MUL_WAIT;
      cnt   <= CNT_W'(MUL_LAT);
    end else if (e_start && !Req && e_is_div) begin
      state <= DIV_WAIT;
      cnt   <= CNT_W'(DIV_LAT);
    end else if (state != IDLE) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) state <= IDLE;
    end
  end

  // E register: Req flushes, a local or external stall inserts a bubble,
  // otherwise the D op and its operands advance.
  always_ff @(posedge clk) begin
    if (reset || Req || stall || ext_stall) begin
      e_type  <= '0;
      e_in1   <= '0;
      e_in2   <= '0;
      e_start <= 1'b0;
    end else begin
      e_type  <= d_type;
      e_in1   <= d_rs;
      e_in2   <= d_rt;
      e_start <= d_launch;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Testbench for mdu_issue_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a cycle-numbered reference model.
module tb_mdu_issue_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [5:0] MULT  = 6'b010101;
  localparam logic [5:0] MULTU = 6'b010110;
  localparam logic [5:0] DIV   = 6'b010111;
  localparam logic [5:0] DIVU  = 6'b011000;
  localparam logic [5:0] MFHI  = 6'b011001;
  localparam logic [5:0] MFLO  = 6'b011010;
  localparam logic [5:0] MTHI  = 6'b011011;
  localparam logic [5:0] MTLO  = 6'b011100;
  localparam logic [5:0] ADDU  = 6'b000000;

  logic        clk = 1'b0;
  logic        reset, Req, ext_stall;
  logic [5:0]  d_type;
  logic [31:0] d_rs, d_rt;
  logic [5:0]  e_type;
  logic [31:0] e_in1, e_in2;
  logic        e_start, stall, busy;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Req(Req), .ext_stall(ext_stall),
    .d_type(d_type), .d_rs(d_rs), .d_rt(d_rt),
    .e_type(e_type), .e_in1(e_in1), .e_in2(e_in2), .e_start(e_start),
    .stall(stall), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: E contents plus the edge number at which the MDU frees.
  logic [5:0]  m_type  = '0;
  logic [31:0] m_in1   = '0;
  logic [31:0] m_in2   = '0;
  logic        m_start = 1'b0;
  int          edge_n  = 0;
  int          free_at = 0;
  logic        last_stall;

  function automatic bit is_md(input logic [5:0] t);
    return t inside {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO};
  endfunction

  function automatic bit is_launch(input logic [5:0] t);
    return t inside {MULT, MULTU, DIV, DIVU};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive D-side inputs, check stall, clock, check E-side.
  task automatic cycle(input logic rst, input logic req, input logic xst,
                       input logic [5:0] t, input logic [31:0] rs, input logic [31:0] rt,
                       input string tag);
    logic exp_stall;
    reset = rst; Req = req; ext_stall = xst;
    d_type = t; d_rs = rs; d_rt = rt;
    #1;
    exp_stall = is_md(t) && (m_start || (edge_n < free_at));
    last_stall = stall;
    check({tag, " stall"}, 32'(stall), 32'(exp_stall));
    @(posedge clk);
    edge_n++;
    if (rst) begin
      m_type = '0; m_in1 = '0; m_in2 = '0; m_start = 1'b0;
      free_at = 0;
    end else begin
      if (m_start && !req)
        free_at = edge_n + ((m_type inside {MULT, MULTU}) ? MUL_LAT : DIV_LAT);
      if (req || exp_stall || xst) begin
        m_type = '0; m_in1 = '0; m_in2 = '0; m_start = 1'b0;
      end else begin
        m_type = t; m_in1 = rs; m_in2 = rt; m_start = is_launch(t);
      end
    end
    #1;
    check({tag, " e_type"},  32'(e_type),  32'(m_type));
    check({tag, " e_in1"},   e_in1,        m_in1);
    check({tag, " e_in2"},   e_in2,        m_in2);
    check({tag, " e_start"}, 32'(e_start), 32'(m_start));
    check({tag, " busy"},    32'(busy),    32'(edge_n < free_at));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, ADDU, 32'h0, 32'h0, tag);
  endtask

  int n_stall, n_busy;
  logic [5:0] op_tab [12];

  initial begin
    reset = 1'b1; Req = 1'b0; ext_stall = 1'b0;
    d_type = '0; d_rs = '0; d_rt = '0;

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, ADDU, 32'h0, 32'h0, "reset");
    cycle(1'b1, 1'b0, 1'b0, MULT, 32'h5, 32'h6, "reset_hold");

    // 1: MULT then dependent MFLO -> stall for 1 + MUL_LAT cycles.
    cycle(1'b0, 1'b0, 1'b0, MULT, 32'h1234_5678, 32'h9abc_def0, "t1_mult");
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 1'b0, MFLO, 32'h0, 32'h0, "t1_mflo");
      if (last_stall) n_stall++;
      else break;
    end
    check("t1 stall cycles", 32'(n_stall), 32'(1 + MUL_LAT));
    check("t1 e_type mflo", 32'(e_type), 32'(MFLO));

    // 2: DIVU then MFHI back-to-back -> 11 stall cycles, 10 busy cycles.
    idle(2, "t2_pre");
    n_stall = 0; n_busy = 0;
    cycle(1'b0, 1'b0, 1'b0, DIVU, 32'hffff_fff0, 32'h3, "t2_divu");
    if (busy) n_busy++;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 1'b0, MFHI, 32'h0, 32'h0, "t2_mfhi");
      if (busy) n_busy++;
      if (last_stall) n_stall++;
      else break;
    end
    check("t2 stall cycles", 32'(n_stall), 32'(1 + DIV_LAT));
    check("t2 busy cycles", 32'(n_busy), 32'(DIV_LAT));
    check("t2 e_type mfhi", 32'(e_type), 32'(MFHI));

    // 3: Req while MULT sits in E cancels it; nothing is left busy.
    idle(1, "t3_pre");
    cycle(1'b0, 1'b0, 1'b0, MULT, 32'h7, 32'h8, "t3_mult");
    cycle(1'b0, 1'b1, 1'b0, ADDU, 32'h1, 32'h2, "t3_req");
    check("t3 busy after cancel", 32'(busy), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, MFLO, 32'h0, 32'h0, "t3_mflo");

    // 4: Req during DIV_WAIT flushes E but the divide keeps counting.
    cycle(1'b0, 1'b0, 1'b0, DIV, 32'h64, 32'h7, "t4_div");
    idle(4, "t4_wait");
    cycle(1'b0, 1'b1, 1'b0, MTLO, 32'h11, 32'h22, "t4_req");
    check("t4 busy after req", 32'(busy), 32'h1);
    idle(7, "t4_drain");
    check("t4 idle after drain", 32'(busy), 32'h0);

    // 5: during MUL_WAIT non-MDU ops flow, MDU ops stall.
    cycle(1'b0, 1'b0, 1'b0, MULTU, 32'h3, 32'h4, "t5_multu");
    cycle(1'b0, 1'b0, 1'b0, ADDU, 32'hdead_beef, 32'h1, "t5_e_start");
    cycle(1'b0, 1'b0, 1'b0, ADDU, 32'hcafe_f00d, 32'h2, "t5_addu");
    check("t5 addu no stall", 32'(last_stall), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, MTHI, 32'h5, 32'h6, "t5_mthi");
    check("t5 mthi stalls", 32'(last_stall), 32'h1);
    idle(4, "t5_drain");

    // 6: reset mid DIV_WAIT, then ext_stall bubbles E.
    cycle(1'b0, 1'b0, 1'b0, DIV, 32'h9, 32'h2, "t6_div");
    idle(7, "t6_wait");
    cycle(1'b1, 1'b0, 1'b0, MFLO, 32'h0, 32'h0, "t6_reset");
    check("t6 busy after reset", 32'(busy), 32'h0);
    cycle(1'b0, 1'b0, 1'b1, DIV, 32'h1, 32'h1, "t6_ext");
    check("t6 ext bubble", 32'(e_start), 32'h0);

    // Random traffic, biased toward MDU codes.
    op_tab = '{MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO,
               ADDU, 6'b100011, 6'b001001, 6'b111111};
    for (int i = 0; i < 600; i++) begin
      logic [5:0] t;
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel < 12) t = op_tab[sel];
      else          t = 6'($urandom);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0), t, $urandom, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
